// File: rtl/program_loader_ctrl.sv
// Loads an instruction/data word stream into the core memories, then
// starts the core and watches for completion, reporting done or a cause-coded error.
module program_loader_ctrl #(
    parameter int WORD_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int IMEM_DEPTH  = 256,
    parameter int DMEM_DEPTH  = 256,
    parameter int RUN_TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              host_valid,
    input  logic [WORD_W-1:0] host_data,
    input  logic              host_sel,
    input  logic              host_last,
    output logic              host_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [WORD_W-1:0] dmem_wdata,
    output logic              start_signal,
    input  logic              end_signal,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   instr_count,
    output logic [ADDR_W:0]   data_count
);
    typedef enum logic [2:0] {IDLE, LOAD_I, LOAD_D, RUN, DONE, ERR} state_t;

    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0]     IMAX   = CW'(IMEM_DEPTH);
    localparam logic [CW-1:0]     DMAX   = CW'(DMEM_DEPTH);
    localparam logic [ADDR_W-1:0] ITOP   = ADDR_W'(IMEM_DEPTH - 1);
    localparam logic [ADDR_W-1:0] DTOP   = ADDR_W'(DMEM_DEPTH - 1);
    localparam logic [31:0]       WD_LIM = 32'(RUN_TIMEOUT - 1);

    state_t            state, state_n;
    logic [ADDR_W-1:0] iptr, dptr;
    logic [31:0]       wd;
    logic              beat, wr_i, wr_d;
    logic [1:0]        code_n;

    assign host_ready   = (state == IDLE) || (state == LOAD_I) || (state == LOAD_D);
    assign busy         = (state == LOAD_I) || (state == LOAD_D) || (state == RUN);
    assign start_signal = (state == RUN);
    assign done         = (state == DONE);
    assign error        = (state == ERR);
    assign beat         = host_valid & host_ready;

    // Overflow and ordering checks are made before any write is issued
    always_comb begin
        state_n = state;
        code_n  = err_code;
        wr_i    = 1'b0;
        wr_d    = 1'b0;
        case (state)
            IDLE: if (beat) begin
                if (host_sel) begin
                    state_n = ERR;
                    code_n  = 2'd2;
                end else begin
                    wr_i    = 1'b1;
                    state_n = host_last ? RUN : LOAD_I;
                end
            end
            LOAD_I: if (beat) begin
                if (host_sel) begin
                    if (data_count == DMAX) begin
                        state_n = ERR;
                        code_n  = 2'd1;
                    end else begin
                        wr_d    = 1'b1;
                        state_n = host_last ? RUN : LOAD_D;
                    end
                end else if (instr_count == IMAX) begin
                    state_n = ERR;
                    code_n  = 2'd1;
                end else begin
                    wr_i    = 1'b1;
                    state_n = host_last ? RUN : LOAD_I;
                end
            end
            LOAD_D: if (beat) begin
                if (!host_sel) begin
                    state_n = ERR;
                    code_n  = 2'd2;
                end else if (data_count == DMAX) begin
                    state_n = ERR;
                    code_n  = 2'd1;
                end else begin
                    wr_d    = 1'b1;
                    state_n = host_last ? RUN : LOAD_D;
                end
            end
            RUN: begin
                if (end_signal) begin
                    state_n = DONE;
                end else if (RUN_TIMEOUT != 0 && wd == WD_LIM) begin
                    state_n = ERR;
                    code_n  = 2'd3;
                end
            end
            DONE:    state_n = DONE;
            ERR:     state_n = ERR;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            err_code    <= 2'd0;
            iptr        <= '0;
            dptr        <= DTOP;
            instr_count <= '0;
            data_count  <= '0;
            wd          <= '0;
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= '0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_wdata  <= '0;
        end else begin
            state    <= state_n;
            err_code <= code_n;
            imem_we  <= wr_i;
            dmem_we  <= wr_d;
            if (wr_i) begin
                imem_addr   <= iptr;
                imem_wdata  <= host_data;
                instr_count <= instr_count + 1'b1;
                if (iptr != ITOP) iptr <= iptr + 1'b1;
            end
            if (wr_d) begin
                dmem_addr  <= dptr;
                dmem_wdata <= host_data;
                data_count <= data_count + 1'b1;
                if (dptr != '0) dptr <= dptr - 1'b1;
            end
            if (state != RUN) wd <= '0;
            else if (wd != '1) wd <= wd + 1'b1;
        end
    end
endmodule

// File: tb/tb_program_loader_ctrl.sv
// Directed bench for program_loader_ctrl: a default instance plus a
// small instance (IMEM_DEPTH=4, RUN_TIMEOUT=20) sharing the host stimulus.
module tb_program_loader_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        host_valid = 1'b0, host_sel = 1'b0, host_last = 1'b0;
    logic        end_signal = 1'b0;
    logic [31:0] host_data = '0;

    logic        a_ready, a_iwe, a_dwe, a_start, a_busy, a_done, a_err;
    logic [7:0]  a_iaddr, a_daddr;
    logic [31:0] a_idata, a_ddata;
    logic [1:0]  a_code;
    logic [8:0]  a_icnt, a_dcnt;

    logic        b_ready, b_iwe, b_dwe, b_start, b_busy, b_done, b_err;
    logic [7:0]  b_iaddr, b_daddr;
    logic [31:0] b_idata, b_ddata;
    logic [1:0]  b_code;
    logic [8:0]  b_icnt, b_dcnt;

    int errors = 0;
    int checks = 0;
    int both_hi = 0;
    logic [7:0]  ia_addr[$], da_addr[$], ib_addr[$];
    logic [31:0] ia_data[$], da_data[$];

    always #5 clk = ~clk;

    program_loader_ctrl dut_a (
        .clk(clk), .reset(reset), .host_valid(host_valid),
        .host_data(host_data), .host_sel(host_sel), .host_last(host_last),
        .host_ready(a_ready), .imem_we(a_iwe), .imem_addr(a_iaddr),
        .imem_wdata(a_idata), .dmem_we(a_dwe), .dmem_addr(a_daddr),
        .dmem_wdata(a_ddata), .start_signal(a_start), .end_signal(end_signal),
        .busy(a_busy), .done(a_done), .error(a_err), .err_code(a_code),
        .instr_count(a_icnt), .data_count(a_dcnt)
    );

    program_loader_ctrl #(.IMEM_DEPTH(4), .RUN_TIMEOUT(20)) dut_b (
        .clk(clk), .reset(reset), .host_valid(host_valid),
        .host_data(host_data), .host_sel(host_sel), .host_last(host_last),
        .host_ready(b_ready), .imem_we(b_iwe), .imem_addr(b_iaddr),
        .imem_wdata(b_idata), .dmem_we(b_dwe), .dmem_addr(b_daddr),
        .dmem_wdata(b_ddata), .start_signal(b_start), .end_signal(end_signal),
        .busy(b_busy), .done(b_done), .error(b_err), .err_code(b_code),
        .instr_count(b_icnt), .data_count(b_dcnt)
    );

    // Write log sampled on the falling edge
    always @(negedge clk) begin
        if (a_iwe) begin
            ia_addr.push_back(a_iaddr);
            ia_data.push_back(a_idata);
        end
        if (a_dwe) begin
            da_addr.push_back(a_daddr);
            da_data.push_back(a_ddata);
        end
        if (b_iwe) ib_addr.push_back(b_iaddr);
        if ((a_iwe && a_dwe) || (b_iwe && b_dwe)) both_hi++;
    end

    // Called at a falling edge; returns at the next one, write visible
    task automatic beat(input logic sel, input logic [31:0] d, input logic last);
        host_valid = 1'b1;
        host_sel   = sel;
        host_data  = d;
        host_last  = last;
        @(negedge clk);
        host_valid = 1'b0;
        host_last  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        end_signal = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        ia_addr.delete(); ia_data.delete();
        da_addr.delete(); da_data.delete();
        ib_addr.delete();
        both_hi = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (a_ready !== 1'b1 || a_busy !== 1'b0 || a_done !== 1'b0 ||
            a_err !== 1'b0 || a_start !== 1'b0 || a_code !== 2'd0) begin
            errors++;
            $display("FAIL reset_flags: ready=%b busy=%b done=%b err=%b start=%b code=%0d want 1 0 0 0 0 0",
                     a_ready, a_busy, a_done, a_err, a_start, a_code);
        end
        checks++;
        if (a_iwe !== 1'b0 || a_dwe !== 1'b0 || a_icnt !== 9'd0 || a_dcnt !== 9'd0) begin
            errors++;
            $display("FAIL reset_mem: iwe=%b dwe=%b icnt=%0d dcnt=%0d want 0 0 0 0",
                     a_iwe, a_dwe, a_icnt, a_dcnt);
        end
    endtask

    task automatic test_load();
        logic [31:0] dv[3];
        dv[0] = 32'hA; dv[1] = 32'h6; dv[2] = 32'hD;
        do_reset();
        for (int i = 0; i < 13; i++) beat(1'b0, 32'h100 + 32'(i), 1'b0);
        beat(1'b1, dv[0], 1'b0);
        beat(1'b1, dv[1], 1'b0);
        beat(1'b1, dv[2], 1'b1);
        checks++;
        if (a_dwe !== 1'b1 || a_daddr !== 8'd253 || a_start !== 1'b1 || a_ready !== 1'b0) begin
            errors++;
            $display("FAIL last_write: dwe=%b addr=%0d start=%b ready=%b want 1 253 1 0",
                     a_dwe, a_daddr, a_start, a_ready);
        end
        @(negedge clk);
        checks++;
        if (ia_addr.size() != 13) begin
            errors++;
            $display("FAIL imem_count: got %0d writes want 13", ia_addr.size());
        end else begin
            for (int i = 0; i < 13; i++) begin
                checks++;
                if (ia_addr[i] !== 8'(i) || ia_data[i] !== 32'h100 + 32'(i)) begin
                    errors++;
                    $display("FAIL imem_write%0d: addr=%0d data=%h want %0d %h",
                             i, ia_addr[i], ia_data[i], i, 32'h100 + 32'(i));
                end
            end
        end
        checks++;
        if (da_addr.size() != 3) begin
            errors++;
            $display("FAIL dmem_count: got %0d writes want 3", da_addr.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (da_addr[i] !== 8'(255 - i) || da_data[i] !== dv[i]) begin
                    errors++;
                    $display("FAIL dmem_write%0d: addr=%0d data=%h want %0d %h",
                             i, da_addr[i], da_data[i], 255 - i, dv[i]);
                end
            end
        end
        checks++;
        if (a_icnt !== 9'd13 || a_dcnt !== 9'd3 || both_hi != 0) begin
            errors++;
            $display("FAIL load_counts: icnt=%0d dcnt=%0d both=%0d want 13 3 0",
                     a_icnt, a_dcnt, both_hi);
        end
    endtask

    task automatic test_done();
        repeat (38) @(negedge clk);
        checks++;
        if (a_start !== 1'b1 || a_done !== 1'b0 || a_busy !== 1'b1) begin
            errors++;
            $display("FAIL run_hold: start=%b done=%b busy=%b want 1 0 1", a_start, a_done, a_busy);
        end
        end_signal = 1'b1;
        @(negedge clk);
        end_signal = 1'b0;
        checks++;
        if (a_done !== 1'b1 || a_start !== 1'b0 || a_busy !== 1'b0 || a_err !== 1'b0) begin
            errors++;
            $display("FAIL done: done=%b start=%b busy=%b err=%b want 1 0 0 0",
                     a_done, a_start, a_busy, a_err);
        end
        beat(1'b0, 32'hDEAD, 1'b0);
        checks++;
        if (a_ready !== 1'b0 || a_iwe !== 1'b0 || a_icnt !== 9'd13 || a_done !== 1'b1) begin
            errors++;
            $display("FAIL done_ignore: ready=%b iwe=%b icnt=%0d done=%b want 0 0 13 1",
                     a_ready, a_iwe, a_icnt, a_done);
        end
    endtask

    task automatic test_first_data();
        do_reset();
        beat(1'b1, 32'h55, 1'b1);
        checks++;
        if (a_iwe !== 1'b0 || a_dwe !== 1'b0 || a_err !== 1'b1 || a_code !== 2'd2 ||
            a_ready !== 1'b0 || a_start !== 1'b0) begin
            errors++;
            $display("FAIL first_data: iwe=%b dwe=%b err=%b code=%0d ready=%b start=%b want 0 0 1 2 0 0",
                     a_iwe, a_dwe, a_err, a_code, a_ready, a_start);
        end
    endtask

    task automatic test_instr_after_data();
        do_reset();
        beat(1'b0, 32'h1, 1'b0);
        beat(1'b0, 32'h2, 1'b0);
        beat(1'b1, 32'h77, 1'b0);
        beat(1'b0, 32'h99, 1'b0);
        checks++;
        if (a_iwe !== 1'b0 || a_err !== 1'b1 || a_code !== 2'd2 ||
            a_icnt !== 9'd2 || a_dcnt !== 9'd1) begin
            errors++;
            $display("FAIL seq_err: iwe=%b err=%b code=%0d icnt=%0d dcnt=%0d want 0 1 2 2 1",
                     a_iwe, a_err, a_code, a_icnt, a_dcnt);
        end
        @(negedge clk);
        checks++;
        if (ia_addr.size() != 2 || da_addr.size() != 1) begin
            errors++;
            $display("FAIL seq_log: iwrites=%0d dwrites=%0d want 2 1", ia_addr.size(), da_addr.size());
        end else begin
            checks++;
            if (ia_data[0] !== 32'h1 || ia_data[1] !== 32'h2 ||
                da_addr[0] !== 8'd255 || da_data[0] !== 32'h77) begin
                errors++;
                $display("FAIL seq_intact: i0=%h i1=%h daddr=%0d d0=%h want 1 2 255 77",
                         ia_data[0], ia_data[1], da_addr[0], da_data[0]);
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 5; i++) beat(1'b0, 32'(i + 1), 1'b0);
        checks++;
        if (b_iwe !== 1'b0 || b_err !== 1'b1 || b_code !== 2'd1 || b_icnt !== 9'd4) begin
            errors++;
            $display("FAIL overflow: iwe=%b err=%b code=%0d icnt=%0d want 0 1 1 4",
                     b_iwe, b_err, b_code, b_icnt);
        end
        @(negedge clk);
        checks++;
        if (ib_addr.size() != 4) begin
            errors++;
            $display("FAIL overflow_log: got %0d writes want 4", ib_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (ib_addr[i] !== 8'(i)) begin
                    errors++;
                    $display("FAIL overflow_addr%0d: got %0d want %0d", i, ib_addr[i], i);
                end
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        beat(1'b0, 32'h1, 1'b0);
        beat(1'b0, 32'h2, 1'b1);
        repeat (19) @(negedge clk);
        checks++;
        if (b_err !== 1'b0 || b_start !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early: err=%b start=%b want 0 1", b_err, b_start);
        end
        @(negedge clk);
        checks++;
        if (b_err !== 1'b1 || b_code !== 2'd3 || b_start !== 1'b0 || b_busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout: err=%b code=%0d start=%b busy=%b want 1 3 0 0",
                     b_err, b_code, b_start, b_busy);
        end
        checks++;
        if (a_err !== 1'b0 || a_start !== 1'b1) begin
            errors++;
            $display("FAIL no_watchdog_a: err=%b start=%b want 0 1", a_err, a_start);
        end
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        beat(1'b0, 32'h1, 1'b0);
        beat(1'b1, 32'h2, 1'b0);
        beat(1'b1, 32'h3, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (a_ready !== 1'b1 || a_busy !== 1'b0 || a_icnt !== 9'd0 ||
            a_dcnt !== 9'd0 || a_dwe !== 1'b0 || a_start !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: ready=%b busy=%b icnt=%0d dcnt=%0d dwe=%b start=%b want 1 0 0 0 0 0",
                     a_ready, a_busy, a_icnt, a_dcnt, a_dwe, a_start);
        end
        beat(1'b0, 32'h4, 1'b0);
        beat(1'b1, 32'hEE, 1'b1);
        checks++;
        if (a_dwe !== 1'b1 || a_daddr !== 8'd255 || a_ddata !== 32'hEE || a_dcnt !== 9'd1) begin
            errors++;
            $display("FAIL mid_reset_dptr: dwe=%b addr=%0d data=%h dcnt=%0d want 1 255 ee 1",
                     a_dwe, a_daddr, a_ddata, a_dcnt);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (a_start !== 1'b0 || a_ready !== 1'b1) begin
            errors++;
            $display("FAIL run_reset: start=%b ready=%b want 0 1", a_start, a_ready);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_done();
        test_first_data();
        test_instr_after_data();
        test_overflow();
        test_timeout();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
